// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
package rf_pkg;

  localparam int unsigned DW_DEF = 32;  // default writeback data width
  localparam int unsigned AW_DEF = 5;   // default register address width

  // Architectural zero register; writes to it are dropped.
  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

  // grant_src encodings
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_M = 1'b1;

endpackage : rf_pkg

// File: rtl/rf_bypass_mux.sv
// Forwards an in-flight register-file write to one read port.
// Only built when RF_WB_BYPASS_EN is defined.
// Ports:
//   rf_we/rf_wr/rf_wd : write currently driven into the register file
//   rr                : read address
//   rf_rd             : raw register-file read data
//   byp_rd            : read data with the in-flight write forwarded (combinational)
`ifdef RF_WB_BYPASS_EN
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          rf_we,
  input  logic [AW-1:0] rf_wr,
  input  logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] rr,
  input  logic [DW-1:0] rf_rd,
  output logic [DW-1:0] byp_rd
);

  // The zero register never forwards; it always reads as the raw value.
  always_comb begin
    byp_rd = rf_rd;
    if (rf_we && (rf_wr == rr) && (rr != AW'(REG_ZERO))) begin
      byp_rd = rf_wd;
    end
  end

endmodule : rf_bypass_mux
`endif

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU (A) and
// memory/load (M) writeback requesters. M has fixed priority; A is forced
// through after losing STARVE_MAX consecutive cycles. One registered stage
// drives the register file.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data  : ALU writeback request (ready is combinational)
//   m_valid/m_ready/m_rd/m_data  : memory writeback request (ready is combinational)
//   rf_we/rf_wr/rf_wd            : registered register-file write port
//   grant_src                    : registered source of the current write (SRC_A/SRC_M)
// Optional feature macro RF_WB_BYPASS_EN adds rR1/rR2, rf_rd1/rf_rd2 inputs and
// byp_rd1/byp_rd2 outputs that forward the in-flight write to two read ports.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0] rR1,
  input  logic [AW-1:0] rR2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic [DW-1:0] byp_rd1,
  output logic [DW-1:0] byp_rd2,
`endif
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic [AW-1:0] m_rd,
  input  logic [DW-1:0] m_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wd,
  output logic          grant_src
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;
  logic          force_a_c;
  logic          xfer_c;
  logic          sel_src_c;
  logic [AW-1:0] sel_rd_c;
  logic [DW-1:0] sel_data_c;

  // Grant and starvation-counter next state.
  always_comb begin
    force_a_c  = (starve_cnt == CW'(STARVE_MAX));
    a_ready    = a_valid && (!m_valid || force_a_c);
    m_ready    = m_valid && !(a_valid && force_a_c);
    xfer_c     = a_ready || m_ready;
    sel_src_c  = SRC_A;
    sel_rd_c   = a_rd;
    sel_data_c = a_data;
    if (m_ready) begin
      sel_src_c  = SRC_M;
      sel_rd_c   = m_rd;
      sel_data_c = m_data;
    end
    starve_nxt = starve_cnt;
    if (!a_valid || a_ready) begin
      starve_nxt = '0;
    end else if (!force_a_c) begin
      starve_nxt = starve_cnt + CW'(1);
    end
  end

  // Output stage and counter register. Writes to the zero register are
  // accepted but never enable the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_wr      <= '0;
      rf_wd      <= '0;
      grant_src  <= SRC_A;
    end else begin
      starve_cnt <= starve_nxt;
      rf_we      <= 1'b0;
      if (xfer_c) begin
        rf_we     <= (sel_rd_c != AW'(REG_ZERO));
        rf_wr     <= sel_rd_c;
        rf_wd     <= sel_data_c;
        grant_src <= sel_src_c;
      end
    end
  end

`ifdef RF_WB_BYPASS_EN
  rf_bypass_mux #(.DW(DW), .AW(AW)) u_byp1 (
    .rf_we (rf_we),
    .rf_wr (rf_wr),
    .rf_wd (rf_wd),
    .rr    (rR1),
    .rf_rd (rf_rd1),
    .byp_rd(byp_rd1)
  );

  rf_bypass_mux #(.DW(DW), .AW(AW)) u_byp2 (
    .rf_we (rf_we),
    .rf_wr (rf_wr),
    .rf_wd (rf_wd),
    .rr    (rR2),
    .rf_rd (rf_rd2),
    .byp_rd(byp_rd2)
  );
`endif

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vectors, a per-cycle
// behavioural model, and literal expectations for the key scenarios.
module tb_rf_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned SM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, m_valid;
  logic          a_ready, m_ready;
  logic [AW-1:0] a_rd, m_rd;
  logic [DW-1:0] a_data, m_data;
  logic          rf_we;
  logic [AW-1:0] rf_wr;
  logic [DW-1:0] rf_wd;
  logic          grant_src;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0] rR1, rR2;
  logic [DW-1:0] rf_rd1, rf_rd2, byp_rd1, byp_rd2;
`endif

  int tests = 0;
  int fails = 0;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef RF_WB_BYPASS_EN
    .rR1      (rR1),
    .rR2      (rR2),
    .rf_rd1   (rf_rd1),
    .rf_rd2   (rf_rd2),
    .byp_rd1  (byp_rd1),
    .byp_rd2  (byp_rd2),
`endif
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_rd     (m_rd),
    .m_data   (m_data),
    .rf_we    (rf_we),
    .rf_wr    (rf_wr),
    .rf_wd    (rf_wd),
    .grant_src(grant_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the register file should see, one cycle after each grant.
  logic          e_we = 1'b0;
  logic [AW-1:0] e_wr = '0;
  logic [DW-1:0] e_wd = '0;
  logic          e_src = 1'b0;
  bit            e_known = 1'b1;  // rf_wr/rf_wd are defined by the model
  int            losses = 0;      // consecutive cycles A waited

  function automatic bit a_wins();
    return a_valid && (!m_valid || losses >= SM);
  endfunction

  always @(posedge clk) begin
    bit aw, mw;
    aw = a_wins();
    mw = m_valid && !aw;
    if (rst) begin
      e_we = 1'b0; e_wr = '0; e_wd = '0; e_src = 1'b0; e_known = 1'b1; losses = 0;
    end else begin
      if (aw || mw) begin
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
        rd = mw ? m_rd : a_rd;
        d  = mw ? m_data : a_data;
        e_src = mw;
        e_we  = (rd != 0);
        if (rd != 0) begin
          e_wr = rd; e_wd = d; e_known = 1'b1;
        end else begin
          e_known = 1'b0;
        end
      end else begin
        e_we = 1'b0;
      end
      losses = (a_valid && !aw) ? losses + 1 : 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit ea;
    ea = a_wins();
    check("a_ready", 64'(a_ready), 64'(ea));
    check("m_ready", 64'(m_ready), 64'(m_valid && !ea));
    check("rf_we", 64'(rf_we), 64'(e_we));
    check("grant_src", 64'(grant_src), 64'(e_src));
    if (e_known) begin
      check("rf_wr", 64'(rf_wr), 64'(e_wr));
      check("rf_wd", 64'(rf_wd), 64'(e_wd));
    end
`ifdef RF_WB_BYPASS_EN
    check("byp_rd1", 64'(byp_rd1), 64'((e_we && e_wr == rR1 && rR1 != 0) ? e_wd : rf_rd1));
    check("byp_rd2", 64'(byp_rd2), 64'((e_we && e_wr == rR2 && rR2 != 0) ? e_wd : rf_rd2));
`endif
  end

  // Register-file image and write log built from what the DUT drives.
  logic [DW-1:0] rf_mem [32];
  logic [DW-1:0] wlog [$];
  bit            log_en = 1'b0;
  always @(negedge clk) begin
    if (rf_we) begin
      rf_mem[rf_wr] = rf_wd;
      if (log_en) wlog.push_back(rf_wd);
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  logic [7:0] gseq;
  logic [7:0] gexp;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; m_valid = 1'b0;
    a_rd = '0; m_rd = '0; a_data = '0; m_data = '0;
`ifdef RF_WB_BYPASS_EN
    rR1 = '0; rR2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;

    // Reset held two cycles with random requests.
    a_valid = 1'($urandom); m_valid = 1'($urandom);
    a_rd = 5'd4; m_rd = 5'd6; a_data = 32'h11; m_data = 32'h22;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_we", 64'(rf_we), 64'd0);
      check("rst_src", 64'(grant_src), 64'd0);
      next_cycle();
      a_valid = 1'($urandom); m_valid = 1'($urandom);
    end
    rst = 1'b0;
    a_valid = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    check("post_rst_we", 64'(rf_we), 64'd0);
    check("post_rst_src", 64'(grant_src), 64'd0);

    // A only.
    next_cycle();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1234;
    @(negedge clk);
    check("aonly_ready", 64'(a_ready), 64'd1);
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    check("aonly_we", 64'(rf_we), 64'd1);
    check("aonly_wr", 64'(rf_wr), 64'd5);
    check("aonly_wd", 64'(rf_wd), 64'h1234);
    check("aonly_src", 64'(grant_src), 64'd0);

    // Idle cycle: write enable drops, address/data hold.
    next_cycle();
    @(negedge clk);
    check("idle_we", 64'(rf_we), 64'd0);
    check("idle_wd", 64'(rf_wd), 64'h1234);

    // Sustained contention: M,M,M,A repeating.
    next_cycle();
    a_valid = 1'b1; m_valid = 1'b1;
    a_rd = 5'd1; a_data = 32'hA1; m_rd = 5'd2; m_data = 32'hB2;
    gexp = 8'b0111_0111;  // bit i = m_ready in cycle i
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gseq[i] = m_ready;
      next_cycle();
    end
    a_valid = 1'b0; m_valid = 1'b0;
    check("contention_seq", 64'(gseq), 64'(gexp));

    // Write to x0 via M.
    next_cycle();
    m_valid = 1'b1; m_rd = 5'd0; m_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("x0_ready", 64'(m_ready), 64'd1);
    next_cycle();
    m_valid = 1'b0;
    @(negedge clk);
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_src", 64'(grant_src), 64'd1);

    // Same destination from both requesters.
    next_cycle();
    log_en = 1'b1;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'd1;
    m_valid = 1'b1; m_rd = 5'd7; m_data = 32'd2;
    @(negedge clk);
    check("samerd_m_first", 64'(m_ready), 64'd1);
    check("samerd_a_wait", 64'(a_ready), 64'd0);
    next_cycle();
    m_valid = 1'b0;
    @(negedge clk);
    check("samerd_a_retry", 64'(a_ready), 64'd1);
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    next_cycle();
    log_en = 1'b0;
    check("samerd_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check("samerd_w0", 64'(wlog[0]), 64'd2);
      check("samerd_w1", 64'(wlog[1]), 64'd1);
    end
    check("samerd_x7", 64'(rf_mem[7]), 64'd1);

    // Reset arriving with an accepted request drops the write.
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h55; rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(a_ready), 64'd1);
    next_cycle();
    rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    check("midrst_we", 64'(rf_we), 64'd0);

`ifdef RF_WB_BYPASS_EN
    // Forwarding of the in-flight write.
    next_cycle();
    rR1 = 5'd3; rR2 = 5'd0; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hAA;
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    check("byp_we", 64'(rf_we), 64'd1);
    check("byp1_fwd", 64'(byp_rd1), 64'hAA);
    check("byp2_raw", 64'(byp_rd2), 64'h22);
    next_cycle();
    @(negedge clk);
    check("byp1_idle", 64'(byp_rd1), 64'h11);
`endif

    next_cycle();
    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rf_wb_arbiter
